// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 multiply sequencer that borrows the core ALU for one pass per cycle.
// Define MULSEQ_SIGNED_EN to add the signed_i port and the CORA/CORB signed correction states.
module alu_mul_seq (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
`ifdef MULSEQ_SIGNED_EN
    input  logic        signed_i,
`endif
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] product_o,
    output logic        z_o,
    output logic        c_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic        alu_c_o,
    output logic        alu_op_add_o,
    output logic        alu_op_sub_o,
    output logic        alu_op_shf_o,
    input  logic [7:0]  alu_s_i,
    input  logic        alu_c_i
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADD  = 3'd1;
    localparam logic [2:0] ST_SHF  = 3'd2;
`ifdef MULSEQ_SIGNED_EN
    localparam logic [2:0] ST_CORA = 3'd3;
    localparam logic [2:0] ST_CORB = 3'd4;
`endif
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]  state_reg,   state_next;
    logic [7:0]  mcand_reg,   mcand_next;
    logic [7:0]  hi_reg,      hi_next;
    logic [7:0]  lo_reg,      lo_next;
    logic        cy_reg,      cy_next;
    logic [2:0]  cnt_reg,     cnt_next;
    logic [15:0] product_reg, product_next;
    logic        z_reg,       z_next;
    logic        c_reg,       c_next;
`ifdef MULSEQ_SIGNED_EN
    logic [7:0]  b_orig_reg,  b_orig_next;
    logic        sgn_reg,     sgn_next;
`endif

    // Partial product for the current multiplier bit: mcand gated by lo[0].
    logic [7:0] add_b;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_add_b
            assign add_b[gi] = lo_reg[0] & mcand_reg[gi];
        end
    endgenerate

    always_comb begin
        alu_a_o      = 8'h00;
        alu_b_o      = 8'h00;
        alu_c_o      = 1'b0;
        alu_op_add_o = 1'b0;
        alu_op_sub_o = 1'b0;
        alu_op_shf_o = 1'b0;
        case (state_reg)
            ST_ADD: begin
                alu_a_o      = hi_reg;
                alu_b_o      = add_b;
                alu_op_add_o = 1'b1;
            end
            ST_SHF: begin
                alu_a_o      = hi_reg;
                alu_c_o      = cy_reg;
                alu_op_shf_o = 1'b1;
            end
`ifdef MULSEQ_SIGNED_EN
            ST_CORA: begin
                alu_a_o      = hi_reg;
                alu_b_o      = mcand_reg[7] ? b_orig_reg : 8'h00;
                alu_op_sub_o = 1'b1;
            end
            ST_CORB: begin
                alu_a_o      = hi_reg;
                alu_b_o      = b_orig_reg[7] ? mcand_reg : 8'h00;
                alu_op_sub_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        cy_next      = cy_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        z_next       = z_reg;
        c_next       = c_reg;
`ifdef MULSEQ_SIGNED_EN
        b_orig_next  = b_orig_reg;
        sgn_next     = sgn_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    mcand_next  = a_i;
                    lo_next     = b_i;
                    hi_next     = 8'h00;
                    cy_next     = 1'b0;
                    cnt_next    = 3'd7;
                    state_next  = ST_ADD;
`ifdef MULSEQ_SIGNED_EN
                    b_orig_next = b_i;
                    sgn_next    = signed_i;
`endif
                end
            end
            ST_ADD: begin
                hi_next    = alu_s_i;
                cy_next    = alu_c_i;
                state_next = ST_SHF;
            end
            ST_SHF: begin
                // The ALU shifts {cy,hi} right; its carry-out is the bit dropping into lo.
                hi_next = alu_s_i;
                lo_next = {alu_c_i, lo_reg[7:1]};
                if (cnt_reg == 3'd0) begin
`ifdef MULSEQ_SIGNED_EN
                    state_next = sgn_reg ? ST_CORA : ST_DONE;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    cnt_next   = cnt_reg - 3'd1;
                    state_next = ST_ADD;
                end
            end
`ifdef MULSEQ_SIGNED_EN
            ST_CORA: begin
                hi_next    = alu_s_i;
                state_next = ST_CORB;
            end
            ST_CORB: begin
                hi_next    = alu_s_i;
                state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                product_next = {hi_reg, lo_reg};
                z_next       = ({hi_reg, lo_reg} == 16'h0000);
                c_next       = hi_reg[7];
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            mcand_reg   <= 8'h00;
            hi_reg      <= 8'h00;
            lo_reg      <= 8'h00;
            cy_reg      <= 1'b0;
            cnt_reg     <= 3'd0;
            product_reg <= 16'h0000;
            z_reg       <= 1'b0;
            c_reg       <= 1'b0;
`ifdef MULSEQ_SIGNED_EN
            b_orig_reg  <= 8'h00;
            sgn_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            cy_reg      <= cy_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            z_reg       <= z_next;
            c_reg       <= c_next;
`ifdef MULSEQ_SIGNED_EN
            b_orig_reg  <= b_orig_next;
            sgn_reg     <= sgn_next;
`endif
        end
    end

    // During DONE the result bypasses the holding registers so it lines up with done_o.
    assign busy_o    = (state_reg != ST_IDLE);
    assign done_o    = (state_reg == ST_DONE);
    assign product_o = done_o ? {hi_reg, lo_reg} : product_reg;
    assign z_o       = done_o ? ({hi_reg, lo_reg} == 16'h0000) : z_reg;
    assign c_o       = done_o ? hi_reg[7] : c_reg;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural core ALU attached to its alu_* lines.
// Signed vectors are exercised when MULSEQ_SIGNED_EN is defined.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        sgn;
    logic        busy, done, z, c;
    logic [15:0] product;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic        alu_cin, alu_cout;
    logic        op_add, op_sub, op_shf;

    int checks = 0;
    int errors = 0;

    alu_mul_seq dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .a_i          (a_in),
        .b_i          (b_in),
`ifdef MULSEQ_SIGNED_EN
        .signed_i     (sgn),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .product_o    (product),
        .z_o          (z),
        .c_o          (c),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_c_o      (alu_cin),
        .alu_op_add_o (op_add),
        .alu_op_sub_o (op_sub),
        .alu_op_shf_o (op_shf),
        .alu_s_i      (alu_s),
        .alu_c_i      (alu_cout)
    );

    // Core ALU: add with carry, subtract with borrow, rotate right through carry.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'h000;
        if (op_add)
            alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
        else if (op_sub)
            alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
        else if (op_shf)
            alu_wide = {alu_a[0], alu_cin, alu_a[7:1]};
        alu_s    = alu_wide[7:0];
        alu_cout = alu_wide[8];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and audit the ALU op lines in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check("op_onehot", {31'd0, ($countones({op_add, op_sub, op_shf}) <= 1)}, 32'd1);
        if (!busy)
            check("idle_alu", {12'd0, op_add, op_sub, op_shf, alu_cin, alu_b, alu_a}, 32'd0);
    endtask

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp_p, input int exp_lat,
                          input logic inj5, input logic inj_done);
        int   cyc;
        int   busy_n;
        logic seen;
        a_in  = a;
        b_in  = b;
        sgn   = s;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && cyc < 40) begin
            if (inj5 && cyc == 5) begin
                start = 1'b1;
                a_in  = 8'h77;
                b_in  = 8'h22;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", cyc, exp_lat);
        check("busy_cycles", busy_n, exp_lat);
        check("product", {16'd0, product}, {16'd0, exp_p});
        check("z_flag", {31'd0, z}, {31'd0, (exp_p == 16'h0000)});
        check("c_flag", {31'd0, c}, {31'd0, exp_p[15]});
        $display("mul a=%h b=%h signed=%0d -> product=%h z=%0d c=%0d latency=%0d",
                 a, b, s, product, z, c, cyc);
        if (inj_done) begin
            start = 1'b1;
            a_in  = 8'h03;
            b_in  = 8'h05;
        end
        tick();
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_done", {31'd0, done}, 32'd0);
        check("post_hold", {16'd0, product}, {16'd0, exp_p});
    endtask

    initial begin
        logic saw;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        sgn   = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_z", {31'd0, z}, 32'd0);
        check("rst_c", {31'd0, c}, 32'd0);
        check("rst_alu", {12'd0, op_add, op_sub, op_shf, alu_cin, alu_b, alu_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_mul(8'd13, 8'd11, 1'b0, 16'h008F, 17, 1'b0, 1'b0);
        do_mul(8'hFF, 8'hFF, 1'b0, 16'hFE01, 17, 1'b0, 1'b0);
        do_mul(8'h00, 8'h5A, 1'b0, 16'h0000, 17, 1'b0, 1'b0);
        // Starts at E0+5 and in DONE are ignored; the held start is then taken in IDLE.
        do_mul(8'h12, 8'h34, 1'b0, 16'h03A8, 17, 1'b1, 1'b1);
        do_mul(8'h03, 8'h05, 1'b0, 16'h000F, 17, 1'b0, 1'b0);

        // Reset while in SHF with cnt=3 (cycle E0+10).
        a_in  = 8'h21;
        b_in  = 8'h09;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_product", {16'd0, product}, 32'd0);
        check("mid_rst_z", {31'd0, z}, 32'd0);
        check("mid_rst_c", {31'd0, c}, 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) saw = 1'b1;
            tick();
        end
        check("mid_rst_quiet", {31'd0, saw}, 32'd0);
        do_mul(8'h21, 8'h09, 1'b0, 16'h0129, 17, 1'b0, 1'b0);

`ifdef MULSEQ_SIGNED_EN
        do_mul(8'hFF, 8'hFF, 1'b1, 16'h0001, 19, 1'b0, 1'b0);
        do_mul(8'h80, 8'h7F, 1'b1, 16'hC080, 19, 1'b0, 1'b0);
        do_mul(8'h80, 8'h7F, 1'b0, 16'h3F80, 17, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
